// File: rtl/pipe_pkg.sv
// Shared opcode constants, scheduler state encoding and source-use record for the
// fetch/decode/execute pipeline control.
package pipe_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I_OP = 7'b0010011;
  localparam logic [6:0] OPC_I_LD = 7'b0000011;
  localparam logic [6:0] OPC_U    = 7'b0110111;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_J    = 7'b1101111;
  localparam logic [6:0] OPC_S    = 7'b0100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } rs_use_t;

endpackage

// File: rtl/rs_use_decode.sv
// Combinational source-register usage decode for the instruction in decode.
// Shared with the forwarding logic, so it only reports which fields are live.
module rs_use_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output rs_use_t     rs_use
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign unused_bits = ^{instr[31:25], instr[14:7]};

  always_comb begin
    rs_use.use_rs1 = 1'b0;
    rs_use.use_rs2 = 1'b0;
    rs_use.rs1     = instr[19:15];
    rs_use.rs2     = instr[24:20];
    case (opcode)
      OPC_R, OPC_B, OPC_S: begin
        rs_use.use_rs1 = 1'b1;
        rs_use.use_rs2 = 1'b1;
      end
      OPC_I_OP, OPC_I_LD: begin
        rs_use.use_rs1 = 1'b1;
      end
      OPC_U, OPC_J: begin
        rs_use.use_rs1 = 1'b0;
      end
      default: begin
        rs_use.use_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline scheduler: turns load-use hazards, taken branches and memory busy into
// per-stage hold/flush/bubble controls, and counts fetch stall cycles.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             req,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic [4:0]       ex_rd_in,
  input  logic             ex_rd_write_in,
  input  logic             ex_mem_read_in,
  input  logic             branch_taken_in,
  input  logic             mem_busy_in,
  output logic             fetch_hold_out,
  output logic             dec_hold_out,
  output logic             ex_bubble_out,
  output logic             ex_hold_out,
  output logic             flush_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam logic [2:0] FlushLoad  = 3'(FLUSH_CYCLES - 1);
  localparam bit         MultiFlush = (FLUSH_CYCLES > 1);

  pipe_state_e      state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  rs_use_t          rs_use;
  logic             load_use;

  rs_use_decode u_rs_use_decode (
    .instr  (instr_in),
    .rs_use (rs_use)
  );

  assign load_use = ex_mem_read_in && ex_rd_write_in && (ex_rd_in != 5'd0) &&
                    ((rs_use.use_rs1 && (rs_use.rs1 == ex_rd_in)) ||
                     (rs_use.use_rs2 && (rs_use.rs2 == ex_rd_in)));

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    fetch_hold_out = 1'b0;
    dec_hold_out   = 1'b0;
    ex_bubble_out  = 1'b0;
    ex_hold_out    = 1'b0;
    flush_out      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken_in) begin
          flush_out   = 1'b1;
          flush_cnt_d = FlushLoad;
          state_d     = MultiFlush ? FLUSH : RUN;
        end else if (mem_busy_in) begin
          fetch_hold_out = 1'b1;
          dec_hold_out   = 1'b1;
          ex_hold_out    = 1'b1;
          state_d        = MEM_WAIT;
        end else if (load_use) begin
          fetch_hold_out = 1'b1;
          dec_hold_out   = 1'b1;
          ex_bubble_out  = 1'b1;
          state_d        = LD_STALL;
        end
      end
      // Execute already holds the bubble; a branch here cannot come from the stalled load.
      LD_STALL: begin
        if (mem_busy_in) begin
          fetch_hold_out = 1'b1;
          dec_hold_out   = 1'b1;
          ex_hold_out    = 1'b1;
          state_d        = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_out = 1'b1;
        if (mem_busy_in) begin
          fetch_hold_out = 1'b1;
          dec_hold_out   = 1'b1;
          ex_hold_out    = 1'b1;
        end
        if (branch_taken_in) begin
          flush_cnt_d = FlushLoad;
        end else if (!mem_busy_in) begin
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end
      // Execute is frozen, so any branch it signals now is re-presented after release.
      MEM_WAIT: begin
        if (mem_busy_in) begin
          fetch_hold_out = 1'b1;
          dec_hold_out   = 1'b1;
          ex_hold_out    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fetch_hold_out && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_out     = state_q;
  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step queues its expected controls, state and stall
// count, then pops and compares them mid-cycle. A second instance checks saturation.
module tb_pipe_ctrl;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LD  = 2'd1;
  localparam logic [1:0] S_FL  = 2'd2;
  localparam logic [1:0] S_MW  = 2'd3;

  // {fetch_hold, dec_hold, ex_bubble, ex_hold, flush}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b11100;
  localparam logic [4:0] C_MEM   = 5'b11010;
  localparam logic [4:0] C_FL    = 5'b00001;
  localparam logic [4:0] C_MEMFL = 5'b11011;

  localparam logic [31:0] ADD_X3_X1_X5 = 32'h005081B3;
  localparam logic [31:0] ADDI_X2_X0   = 32'h00500113;
  localparam logic [31:0] ADDI_X2_X1   = 32'h00508113;
  localparam logic [31:0] LUI_X1       = 32'h123450B7;
  localparam logic [31:0] NOP          = 32'h00000013;

  typedef struct {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] stall;
    logic        br;
  } exp_t;

  logic        req = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [4:0]  ex_rd_in;
  logic        ex_rd_write_in, ex_mem_read_in, branch_taken_in, mem_busy_in;
  logic        fetch_hold_out, dec_hold_out, ex_bubble_out, ex_hold_out, flush_out;
  logic [1:0]  state_out;
  logic [15:0] stall_cnt_out;
  logic        s_fetch_hold, s_dec_hold, s_ex_bubble, s_ex_hold, s_flush;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_stall = 0;

  always #5 req = ~req;

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .req             (req),
    .reset           (reset),
    .instr_in        (instr_in),
    .ex_rd_in        (ex_rd_in),
    .ex_rd_write_in  (ex_rd_write_in),
    .ex_mem_read_in  (ex_mem_read_in),
    .branch_taken_in (branch_taken_in),
    .mem_busy_in     (mem_busy_in),
    .fetch_hold_out  (fetch_hold_out),
    .dec_hold_out    (dec_hold_out),
    .ex_bubble_out   (ex_bubble_out),
    .ex_hold_out     (ex_hold_out),
    .flush_out       (flush_out),
    .state_out       (state_out),
    .stall_cnt_out   (stall_cnt_out)
  );

  // Single-cycle flush and a 2-bit counter that saturates at 3.
  pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_sat (
    .req             (req),
    .reset           (reset),
    .instr_in        (instr_in),
    .ex_rd_in        (ex_rd_in),
    .ex_rd_write_in  (ex_rd_write_in),
    .ex_mem_read_in  (ex_mem_read_in),
    .branch_taken_in (branch_taken_in),
    .mem_busy_in     (mem_busy_in),
    .fetch_hold_out  (s_fetch_hold),
    .dec_hold_out    (s_dec_hold),
    .ex_bubble_out   (s_ex_bubble),
    .ex_hold_out     (s_ex_hold),
    .flush_out       (s_flush),
    .state_out       (s_state),
    .stall_cnt_out   (s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] rd, input logic rdw,
                       input logic mr, input logic br, input logic mb,
                       input logic [4:0] ctl, input logic [1:0] st);
    exp_t e;
    instr_in        = ins;
    ex_rd_in        = rd;
    ex_rd_write_in  = rdw;
    ex_mem_read_in  = mr;
    branch_taken_in = br;
    mem_busy_in     = mb;
    e.ctl   = ctl;
    e.st    = st;
    e.stall = exp_stall;
    e.br    = br;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t        e;
    logic [31:0] sat_exp;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    sat_exp = (exp_stall > 32'd3) ? 32'd3 : exp_stall;
    chk({tag, "/ctl"}, 32'({fetch_hold_out, dec_hold_out, ex_bubble_out, ex_hold_out,
                            flush_out}), 32'(e.ctl));
    chk({tag, "/state"}, 32'(state_out), 32'(e.st));
    chk({tag, "/stall"}, 32'(stall_cnt_out), e.stall);
    chk({tag, "/sat_stall"}, 32'(s_stall_cnt), sat_exp);
    chk({tag, "/sat_flush"}, 32'(s_flush), 32'(e.ctl[0] && (e.st == S_RUN || e.br)));
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [4:0] rd,
                      input logic rdw, input logic mr, input logic br, input logic mb,
                      input logic [4:0] ctl, input logic [1:0] st);
    drive(ins, rd, rdw, mr, br, mb, ctl, st);
    @(negedge req);
    compare(tag);
    @(posedge req);
    #1;
    if (ctl[4] && exp_stall != 32'hFFFF) exp_stall++;
  endtask

  initial begin
    reset = 1'b1;
    drive(NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, S_RUN);
    @(negedge req);
    compare("reset");
    @(posedge req);
    #1 reset = 1'b0;

    // Load-use on rs2: one stall cycle, then back to RUN.
    step("lu_rs2",    ADD_X3_X1_X5, 5'd5, 1, 1, 0, 0, C_LU,   S_RUN);
    step("lu_stall",  ADD_X3_X1_X5, 5'd5, 1, 1, 0, 0, C_NONE, S_LD);
    step("lu_done",   ADD_X3_X1_X5, 5'd5, 0, 0, 0, 0, C_NONE, S_RUN);
    step("x0_src",    ADDI_X2_X0,   5'd0, 1, 1, 0, 0, C_NONE, S_RUN);
    step("iop_rs2",   ADDI_X2_X1,   5'd5, 1, 1, 0, 0, C_NONE, S_RUN);
    step("lui_rd1",   LUI_X1,       5'd1, 1, 1, 0, 0, C_NONE, S_RUN);
    step("lui_rs1f",  LUI_X1,       5'd8, 1, 1, 0, 0, C_NONE, S_RUN);
    step("no_wr",     ADD_X3_X1_X5, 5'd5, 0, 1, 0, 0, C_NONE, S_RUN);

    // Single branch: two flush cycles.
    step("br1_a",     NOP, 5'd0, 0, 0, 1, 0, C_FL,   S_RUN);
    step("br1_b",     NOP, 5'd0, 0, 0, 0, 0, C_FL,   S_FL);
    step("br1_end",   NOP, 5'd0, 0, 0, 0, 0, C_NONE, S_RUN);

    // Second branch in flush cycle 2 extends the flush to three cycles.
    step("br2_a",     NOP, 5'd0, 0, 0, 1, 0, C_FL,   S_RUN);
    step("br2_b",     NOP, 5'd0, 0, 0, 1, 0, C_FL,   S_FL);
    step("br2_c",     NOP, 5'd0, 0, 0, 0, 0, C_FL,   S_FL);
    step("br2_end",   NOP, 5'd0, 0, 0, 0, 0, C_NONE, S_RUN);

    // Memory wait with a pending load-use; branch is ignored while frozen.
    step("mw_1",      ADD_X3_X1_X5, 5'd5, 1, 1, 0, 1, C_MEM,  S_RUN);
    step("mw_2",      ADD_X3_X1_X5, 5'd5, 1, 1, 0, 1, C_MEM,  S_MW);
    step("mw_3_br",   ADD_X3_X1_X5, 5'd5, 1, 1, 1, 1, C_MEM,  S_MW);
    step("mw_4",      ADD_X3_X1_X5, 5'd5, 1, 1, 0, 1, C_MEM,  S_MW);
    step("mw_rel",    ADD_X3_X1_X5, 5'd5, 1, 1, 0, 0, C_NONE, S_MW);
    step("mw_lu",     ADD_X3_X1_X5, 5'd5, 1, 1, 0, 0, C_LU,   S_RUN);
    step("ld_br_ign", NOP,          5'd0, 0, 0, 1, 0, C_NONE, S_LD);
    step("mw_end",    NOP,          5'd0, 0, 0, 0, 0, C_NONE, S_RUN);

    // Busy during flush: holds win in decode and the flush count is frozen.
    step("flb_a",     NOP, 5'd0, 0, 0, 1, 0, C_FL,    S_RUN);
    step("flb_busy",  NOP, 5'd0, 0, 0, 0, 1, C_MEMFL, S_FL);
    step("flb_c",     NOP, 5'd0, 0, 0, 0, 0, C_FL,    S_FL);
    step("flb_end",   NOP, 5'd0, 0, 0, 0, 0, C_NONE,  S_RUN);

    // Branch beats memory busy beats load-use.
    step("prio",      ADD_X3_X1_X5, 5'd5, 1, 1, 1, 1, C_FL,   S_RUN);
    step("prio_fl",   NOP,          5'd0, 0, 0, 0, 0, C_FL,   S_FL);
    step("prio_end",  NOP,          5'd0, 0, 0, 0, 0, C_NONE, S_RUN);

    // Asynchronous reset in the middle of a flush, with no clock edge in between.
    step("rst_br",    NOP, 5'd0, 0, 0, 1, 0, C_FL, S_RUN);
    drive(NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FL, S_FL);
    @(negedge req);
    compare("rst_pre");
    #2 reset = 1'b1;
    exp_stall = 0;
    #1;
    drive(NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, S_RUN);
    compare("rst_async");
    @(posedge req);
    #1 reset = 1'b0;
    step("post_rst",  NOP, 5'd0, 0, 0, 0, 0, C_NONE, S_RUN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline scheduler for the fetch/decode/execute datapath. It watches the instruction in decode, the instruction in execute, the taken-branch signal and data-memory busy. From these it generates per-stage hold, flush and bubble controls. Decode consumes `dec_hold_out` on its `rs_read` input and `flush_out` on its `reset` input; fetch and execute consume the remaining controls.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush_out` stays high per taken branch. Legal range 1..7.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `req`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high. Returns all state to reset values immediately.
- `instr_in`  in  32: instruction currently in decode.
- `ex_rd_in`  in  5: destination register of the instruction in execute.
- `ex_rd_write_in`  in  1: instruction in execute writes `ex_rd_in`.
- `ex_mem_read_in`  in  1: instruction in execute is a load.
- `branch_taken_in`  in  1: execute resolved a taken branch or jump this cycle.
- `mem_busy_in`  in  1: data memory cannot accept or return this cycle.
- `fetch_hold_out`  out  1: fetch keeps its PC and instruction.
- `dec_hold_out`  out  1: decode does not update its output registers.
- `ex_bubble_out`  out  1: execute latches a NOP instead of decode's output.
- `ex_hold_out`  out  1: execute and memory stages freeze.
- `flush_out`  out  1: fetch and decode contents are discarded.
- `state_out`  out  2: current FSM state.
- `stall_cnt_out`  out  CNT_W: count of cycles with `fetch_hold_out` high. Saturates at all-ones.

## Operation
- **Source-use decode** (opcode = `instr_in[6:0]`):
  - R-type 0110011, B-type 1100011, S-type 0100011: use rs1 (`[19:15]`) and rs2 (`[24:20]`).
  - I-op 0010011, I-load 0000011: use rs1 only.
  - U 0110111, J 1101111, and all other opcodes: use neither.
- **load_use** is true when `ex_mem_read_in` & `ex_rd_write_in` & `ex_rd_in != 0` & (`ex_rd_in` equals a used source register).
- **FSM states:**
  - RUN = 0
  - LD_STALL = 1
  - FLUSH = 2
  - MEM_WAIT = 3
- **Priority in RUN:** `branch_taken_in` > `mem_busy_in` > load_use.
  - `branch_taken_in`: assert `flush_out`, load `flush_cnt = FLUSH_CYCLES-1`. Go to FLUSH if `FLUSH_CYCLES > 1`, else stay in RUN.
  - `mem_busy_in`: assert `fetch_hold_out`, `dec_hold_out`, `ex_hold_out`. Go to MEM_WAIT.
  - load_use: assert `fetch_hold_out`, `dec_hold_out`, `ex_bubble_out`. Go to LD_STALL.
- **LD_STALL:** no load_use check (execute now holds the bubble), and `branch_taken_in` is ignored.
  - `mem_busy_in` high: act as MEM_WAIT entry.
  - Otherwise: return to RUN with no controls asserted.
- **FLUSH:** `flush_out` = 1 every cycle; `flush_cnt` decrements.
  - When `flush_cnt` = 1 and is decremented, go to RUN.
  - A new `branch_taken_in` reloads `flush_cnt = FLUSH_CYCLES-1` and keeps the state in FLUSH.
  - `mem_busy_in` also asserts all three holds; `flush_cnt` does not decrement while busy.
- **MEM_WAIT:** all three holds stay high while `mem_busy_in`.
  - Return to RUN on the first edge with `mem_busy_in` = 0; the holds drop combinationally in that same cycle.
  - `branch_taken_in` is ignored, because execute is frozen and will re-present it.
- **Output encoding:** all `*_out` controls are combinational from (state, inputs); state, `flush_cnt` and `stall_cnt` are registered.
- **Hold/flush conflict:** `flush_out` and `dec_hold_out` are never high together, except FLUSH with `mem_busy_in` high; there, hold wins in decode.

## Timing
- Reset values:
  - state = RUN, `flush_cnt` = 0, `stall_cnt_out` = 0.
  - All controls 0 while `reset` is high and in the first cycle after release, unless inputs request otherwise.
- Latency: hazard-to-control is 0 cycles (same cycle, combinational); the next state takes effect at the next `posedge req`.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs `FLUSH_CYCLES` flush cycles.
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts immediately: state = RUN, counters cleared.
- `stall_cnt_out` increments on each edge where `fetch_hold_out` was high, and holds at 2^CNT_W-1.

## Structure
- Package `pipe_pkg` holds:
  - opcode constants (R, I_op, I_ld, U, B, J, S);
  - the `pipe_state_e` enum (RUN, LD_STALL, FLUSH, MEM_WAIT, 2-bit).
- Sub-module `rs_use_decode`, combinational, maps `instr_in` to `{use_rs1, use_rs2, rs1, rs2}`. It is reused by the forwarding logic later.

## Test plan
- Load-use, rs2 match: `instr_in` = `add x3,x1,x5` (0x005081B3), `ex_mem_read_in`=1, `ex_rd_write_in`=1, `ex_rd_in`=5.
  - Required: hold+bubble for 1 cycle, `state_out` 1 then 0, `stall_cnt_out`=1.
- x0 and don't-care sources:
  - `ex_rd_in`=0 with a matching `instr_in` rs field: no stall.
  - `lui x1,0x12345` (0x123450B7) with `ex_rd_in`=1 (a rs1/rs2 field that decodes to x1 is not used): no stall.
- Branch flush, `FLUSH_CYCLES`=2: pulse `branch_taken_in` for 1 cycle.
  - Required: `flush_out` high for exactly 2 cycles, state RUN→FLUSH→RUN.
  - A second pulse in cycle 2 extends the flush to 3 cycles total.
- Memory wait: `mem_busy_in` high for 4 cycles with a simultaneous load_use.
  - Required: all holds high for 4 cycles, `ex_bubble_out`=0, `stall_cnt_out`=4.
  - After release: the load-use stall follows, giving `stall_cnt_out`=5.
- Priority: `branch_taken_in`, `mem_busy_in` and load_use all high in RUN.
  - Required: only `flush_out`=1, next state FLUSH.
- Async reset: assert `reset` mid-edge-cycle during FLUSH with `stall_cnt_out`=7.
  - Required: outputs clear without a clock edge; state 0, count 0.
